// File: rtl/fifo_rr_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rr_drain
//  Purpose  : Round-robin read scheduler. Drains NUM_CH show-ahead FIFOs into
//             one registered valid/ready stream. One channel is granted at a
//             time, for bursts of up to BURST_LEN words. Each output word is
//             tagged with the channel it came from.
//  Ports    : clk_i, arst_n_i       clock, async active-low reset
//             en_mask_i             per-channel enable
//             fifo_empty_i/fifo_q_i show-ahead FIFO status and head word
//             fifo_rdreq_o          one-hot-or-zero pop request
//             data_o/ch_o/valid_o   registered output word, its channel, valid
//             ready_i               downstream accept
//             busy_o                word held or any channel eligible
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rr_drain #(
  parameter int  NUM_CH    = 4,
  parameter int  DWIDTH    = 8,
  parameter int  BURST_LEN = 4,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [NUM_CH-1:0]        en_mask_i,
  input  logic [NUM_CH-1:0]        fifo_empty_i,
  input  logic [NUM_CH*DWIDTH-1:0] fifo_q_i,
  output logic [NUM_CH-1:0]        fifo_rdreq_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_cur, w_cur_nxt;
  logic [CH_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DWIDTH-1:0]   r_data;
  logic [CH_W-1:0]     r_ch;
  logic                r_valid;

  logic [NUM_CH-1:0]   w_elig;
  logic                w_slot_free;
  logic                w_load;
  logic                w_continue;
  logic [CH_W-1:0]     w_cur_inc;
  logic [CH_W-1:0]     w_scan_start;
  logic [CH_W-1:0]     w_scan_g;
  logic                w_scan_hit;
  logic [CH_W-1:0]     w_grant;
  logic [NUM_CH-1:0]   w_rdreq;

  assign w_elig      = en_mask_i & ~fifo_empty_i;
  assign w_slot_free = !r_valid || ready_i;
  assign w_load      = w_slot_free && (|w_elig);

  // Explicit wrap so non-power-of-2 channel counts rotate correctly.
  assign w_cur_inc   = (r_cur == CH_W'(NUM_CH - 1)) ? '0 : r_cur + CH_W'(1);

  // Staying on the current channel needs it still eligible and burst room left.
  assign w_continue  = (r_state == ST_BURST) && w_elig[r_cur] &&
                       (r_cnt < CNT_W'(BURST_LEN));

  // In BURST the scan starts after cur, so cur itself is visited last.
  assign w_scan_start = (r_state == ST_IDLE) ? r_ptr : w_cur_inc;

  always_comb begin : p_scan
    int idx;
    idx        = 0;
    w_scan_g   = '0;
    w_scan_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(w_scan_start) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_scan_hit && w_elig[idx]) begin
        w_scan_hit = 1'b1;
        w_scan_g   = CH_W'(idx);
      end
    end
  end

  assign w_grant = w_continue ? r_cur : w_scan_g;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_rdreq     = '0;
    if (w_load && w_scan_hit) begin
      w_rdreq[w_grant] = 1'b1;
      w_state_nxt      = ST_BURST;
      w_cur_nxt        = w_grant;
      w_cnt_nxt        = w_continue ? r_cnt + CNT_W'(1) : CNT_W'(1);
    end else if (w_slot_free && (r_state == ST_BURST)) begin
      // Nothing left to send: remember where to resume the rotation.
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = w_cur_inc;
    end
  end

  // Pop requests are gated by reset directly so no FIFO is popped while held.
  assign fifo_rdreq_o = arst_n_i ? w_rdreq : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_data  <= fifo_q_i[int'(w_grant)*DWIDTH +: DWIDTH];
        r_ch    <= w_grant;
        r_valid <= 1'b1;
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o  = r_data;
  assign ch_o    = r_ch;
  assign valid_o = r_valid;
  assign busy_o  = r_valid || (|w_elig);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rr_drain
//  Purpose  : Self-checking bench for fifo_rr_drain. FIFOs are modelled as
//             queues; a behavioural scheduler model predicts pops and output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rr_drain;

  localparam int NUM_CH    = 4;
  localparam int DWIDTH    = 8;
  localparam int BURST_LEN = 4;
  localparam int CH_W      = 2;

  logic                     clk_i = 1'b0;
  logic                     arst_n_i;
  logic [NUM_CH-1:0]        en_mask_i;
  logic [NUM_CH-1:0]        fifo_empty_i;
  logic [NUM_CH*DWIDTH-1:0] fifo_q_i;
  logic [NUM_CH-1:0]        fifo_rdreq_o;
  logic [DWIDTH-1:0]        data_o;
  logic [CH_W-1:0]          ch_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     busy_o;

  always #5 clk_i = ~clk_i;

  fifo_rr_drain #(.NUM_CH(NUM_CH), .DWIDTH(DWIDTH), .BURST_LEN(BURST_LEN)) u_dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .en_mask_i    (en_mask_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .data_o       (data_o),
    .ch_o         (ch_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  logic [DWIDTH-1:0] q [NUM_CH][$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit                m_valid;
  logic [DWIDTH-1:0] m_data;
  int                m_ch;
  bit                m_inburst;
  int                m_cur, m_cnt, m_ptr;

  int ch_log[$];
  int pops_ch2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_data = '0; m_ch = 0;
    m_inburst = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NUM_CH; k++) begin
      fifo_empty_i[k] = (q[k].size() == 0);
      fifo_q_i[k*DWIDTH +: DWIDTH] = (q[k].size() != 0) ? q[k][0] : '0;
    end
  endtask

  function automatic int first_elig(input int start, input logic [NUM_CH-1:0] el);
    for (int i = 0; i < NUM_CH; i++) begin
      if (el[(start + i) % NUM_CH]) return (start + i) % NUM_CH;
    end
    return -1;
  endfunction

  // One clock cycle: check held output, apply stimulus, predict the grant,
  // then advance model and FIFOs across the clock edge.
  task automatic cycle(input bit rdy, input logic [NUM_CH-1:0] en, input bit do_push);
    int g;
    bit slot, cont;
    logic [NUM_CH-1:0] el, exp_rq, rq_seen;
    @(negedge clk_i);
    check("valid", valid_o, m_valid);
    if (m_valid) begin
      check("data", data_o, m_data);
      check("ch", ch_o, m_ch);
      ch_log.push_back(int'(ch_o));
    end
    ready_i   = rdy;
    en_mask_i = en;
    if (do_push)
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 2) == 0 && q[k].size() < 12) q[k].push_back(DWIDTH'($urandom));
    drive_fifos();
    #1;
    for (int k = 0; k < NUM_CH; k++) el[k] = en[k] && (q[k].size() > 0);
    slot = !m_valid || rdy;
    g    = -1;
    cont = 0;
    if (slot && el != 0) begin
      if (!m_inburst) g = first_elig(m_ptr, el);
      else if (el[m_cur] && m_cnt < BURST_LEN) begin g = m_cur; cont = 1; end
      else g = first_elig(m_cur + 1, el);
    end
    exp_rq = '0;
    if (g >= 0) exp_rq[g] = 1'b1;
    check("rdreq", fifo_rdreq_o, exp_rq);
    check("busy", busy_o, m_valid || (el != 0));
    rq_seen = fifo_rdreq_o;
    if (rq_seen[2]) pops_ch2++;
    @(posedge clk_i);
    if (slot) begin
      if (g >= 0) begin
        m_data    = q[g][0];
        m_ch      = g;
        m_valid   = 1;
        m_cnt     = cont ? m_cnt + 1 : 1;
        m_cur     = g;
        m_inburst = 1;
      end else begin
        m_valid = 0;
        if (m_inburst) begin
          m_inburst = 0;
          m_ptr     = (m_cur + 1) % NUM_CH;
        end
      end
    end
    #1;
    for (int k = 0; k < NUM_CH; k++)
      if (rq_seen[k] && q[k].size() > 0) void'(q[k].pop_front());
    drive_fifos();
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) q[k].push_back(DWIDTH'($urandom));
  endtask

  task automatic clear_all();
    for (int k = 0; k < NUM_CH; k++) q[k].delete();
  endtask

  initial begin
    arst_n_i  = 1'b0;
    ready_i   = 1'b0;
    en_mask_i = '0;
    clear_all();
    drive_fifos();
    m_reset();
    #1;
    check("rst_rdreq", fifo_rdreq_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ch", ch_o, 0);
    repeat (2) @(posedge clk_i);
    #1 arst_n_i = 1'b1;

    // All channels hold 10 words, consumer always ready: bursts of 4 in order.
    for (int k = 0; k < NUM_CH; k++) fill(k, 10);
    ch_log.delete();
    repeat (45) cycle(1'b1, 4'hF, 1'b0);
    check("seq_len", ch_log.size(), 40);
    for (int i = 0; i < 16; i++) check("seq_ch", ch_log[i], (i / 4) % 4);

    // Only ch2 has 6 words: continuous stream, exactly 6 pops, then ptr=3.
    repeat (3) cycle(1'b1, 4'hF, 1'b0);
    clear_all();
    fill(2, 6);
    pops_ch2 = 0;
    repeat (10) cycle(1'b1, 4'hF, 1'b0);
    check("ch2_pops", pops_ch2, 6);
    for (int k = 0; k < NUM_CH; k++) fill(k, 1);
    cycle(1'b1, 4'hF, 1'b0);
    #2 check("ptr_after_idle", ch_o, 3);

    // Backpressure pattern 1,0,0,1 with all channels full.
    for (int k = 0; k < NUM_CH; k++) fill(k, 8);
    for (int i = 0; i < 24; i++) cycle((i % 4 == 0) || (i % 4 == 3), 4'hF, 1'b0);

    // Mask 1010, then drop ch1 mid-burst.
    for (int k = 0; k < NUM_CH; k++) fill(k, 8);
    repeat (7) cycle(1'b1, 4'b1010, 1'b0);
    repeat (6) cycle(1'b1, 4'b1000, 1'b0);

    // Channel running dry after 2 words of a burst.
    repeat (20) cycle(1'b1, 4'hF, 1'b0);
    clear_all();
    fill(0, 2); fill(1, 5);
    repeat (10) cycle(1'b1, 4'hF, 1'b0);

    // Reset mid-stream with a word held.
    for (int k = 0; k < NUM_CH; k++) fill(k, 4);
    cycle(1'b1, 4'hF, 1'b0);
    cycle(1'b1, 4'hF, 1'b0);
    #2 arst_n_i = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_rdreq", fifo_rdreq_o, 0);
    m_reset();
    @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    cycle(1'b1, 4'hF, 1'b0);
    #2 check("rst_first_ch", ch_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] en;
      en = (i % 50 < 25) ? 4'hF : NUM_CH'($urandom);
      cycle($urandom_range(0, 3) != 0, en, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
